// File: rtl/four_input_or_gate_checker.sv
// -----------------------------------------------------------------------------
// four_input_or_gate_checker
//
// Response checker for the four-input OR gate block. It watches the applied
// stimulus vector {a,b,c,d} and the gate outputs e,f,g. Each distinct vector
// is checked once it has been stable long enough, against
//   e = a|b, f = c|d, g = a|b|c|d.
// The checker records which of the 16 vectors were seen, how many mismatched,
// and the first mismatching vector. A run ends on full coverage or when no new
// vector arrives in time.
//
// Parameters
//   SETTLE_CYCLES   stable cycles before a vector is sampled (1..15)
//   TIMEOUT_CYCLES  max cycles waiting for a new vector (>= SETTLE_CYCLES+2)
//   CNT_W           width of err_cnt (saturating)
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           1-cycle pulse, begins a run (accepted in IDLE/DONE only)
//   a,b,c,d         applied stimulus (a = vector bit 3, d = bit 0)
//   e,f,g           gate outputs under check
//   busy            run in progress
//   done            run finished, held until next start
//   pass            valid with done: full coverage, no errors, no timeout
//   timeout         valid with done: run aborted waiting for a vector
//   err_cnt         mismatching vectors this run, saturating
//   cov_mask        bit v set once vector v has been checked
//   first_fail_vld  a mismatch has been recorded this run
//   first_fail_vec  vector of the first mismatch
//   fail_mask       (FOUR_OR_CHK_FAIL_MASK_EN only) bit v set when vector v
//                   mismatched at any time in the run
//
// Optional feature macro: FOUR_OR_CHK_FAIL_MASK_EN
// -----------------------------------------------------------------------------
module four_input_or_gate_checker #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      cov_mask,
  output logic             first_fail_vld,
  output logic [3:0]       first_fail_vec
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
  ,
  output logic [15:0]      fail_mask
`endif
);

  localparam int              TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  // Terminal values: the counter "reaches" its limit on the edge that leaves
  // these values, so compare against limit-1.
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  logic [3:0]        vec;
  logic [3:0]        vec_q;
  logic [2:0]        rsp_q;
  logic [2:0]        exp_rsp;
  logic              chg;
  logic              chg_pend;
  logic              mismatch;
  logic [3:0]        settle_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       vec_hit;
  logic [15:0]       cov_next;
  logic [CNT_W-1:0]  err_next;

  assign vec      = {a, b, c, d};
  assign chg      = (vec != vec_q);
  assign exp_rsp  = {vec_q[3] | vec_q[2], vec_q[1] | vec_q[0], |vec_q};
  assign mismatch = (rsp_q != exp_rsp);

  // One-hot decode of the vector under check, used to update coverage.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_hit
      assign vec_hit[gi] = (vec_q == 4'(gi));
    end
  endgenerate

  assign cov_next = cov_mask | vec_hit;

  always_comb begin
    err_next = err_cnt;
    if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
      err_next = err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec_q          <= '0;
      rsp_q          <= '0;
      chg_pend       <= 1'b0;
      settle_cnt     <= '0;
      to_cnt         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      cov_mask       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
      fail_mask      <= '0;
`endif
    end else begin
      vec_q <= vec;
      rsp_q <= {e, f, g};

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= SETTLE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            cov_mask       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            settle_cnt     <= '0;
            to_cnt         <= '0;
            chg_pend       <= 1'b0;
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
            fail_mask      <= '0;
`endif
          end
        end

        SETTLE: begin
          // The timeout keeps running here so a vector that never settles
          // still ends the run.
          if (to_cnt == TO_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (chg) begin
              settle_cnt <= '0;
            end else if (settle_cnt == SETTLE_LAST) begin
              state <= CHECK;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end

        CHECK: begin
          err_cnt  <= err_next;
          cov_mask <= cov_next;
          if (mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= vec_q;
          end
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
          if (mismatch) begin
            fail_mask <= fail_mask | vec_hit;
          end
`endif
          // vec_q already follows the input this cycle, so a change seen now
          // would be invisible to WAIT; remember it instead.
          chg_pend <= chg;
          if (&cov_next) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (to_cnt == TO_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else if (chg || chg_pend) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            to_cnt     <= '0;
            chg_pend   <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_input_or_gate_checker.sv
module tb_four_input_or_gate_checker;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       vec_drv;
  logic [15:0]      fault_mask;
  logic             a, b, c, d, e, f, g;
  logic             busy, done, pass, timeout;
  logic [CNT_W-1:0] err_cnt;
  logic [15:0]      cov_mask;
  logic             first_fail_vld;
  logic [3:0]       first_fail_vec;
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
  logic [15:0]      fail_mask;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] err;
    logic [15:0]      cov;
    logic             ffv;
    logic [3:0]       ffvec;
    logic [15:0]      fmask;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] seq_q[$];

  // Behavioural OR gate under check, with per-vector fault injection on g.
  assign {a, b, c, d} = vec_drv;
  assign e = a | b;
  assign f = c | d;
  assign g = fault_mask[vec_drv] ? 1'b0 : (a | b | c | d);

  four_input_or_gate_checker #(
    .SETTLE_CYCLES (2),
    .TIMEOUT_CYCLES(64),
    .CNT_W         (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .e             (e),
    .f             (f),
    .g             (g),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_cnt       (err_cnt),
    .cov_mask      (cov_mask),
    .first_fail_vld(first_fail_vld),
    .first_fail_vec(first_fail_vec)
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
    ,
    .fail_mask     (fail_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Drives each queued vector for 5 cycles; start pulses with the first
  // vector and again (to be ignored) at index poke.
  task automatic run_seq(input int poke);
    for (int i = 0; i < seq_q.size(); i++) begin
      vec_drv = seq_q[i];
      for (int k = 0; k < 5; k++) begin
        start = (k == 0) && ((i == 0) || (i == poke));
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic fill_full_sweep();
    seq_q = {};
    for (int v = 0; v < 16; v++) seq_q.push_back(4'(v));
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    obs = {busy, done, pass, timeout, err_cnt, cov_mask, first_fail_vld, first_fail_vec};
    checks++;
    if (obs !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    $display("reset: outputs=%h", obs);
  endtask

  task automatic test_sweep();
    exp_t x;
    bit   ok;
    fault_mask = 16'h0000;
    fill_full_sweep();
    sb.push_back('{pass: 1'b1, timeout: 1'b0, err: '0, cov: 16'hFFFF, ffv: 1'b0, ffvec: 4'h0, fmask: 16'h0000});
    run_seq(8);
    wait_done(200, ok);
    x = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL sweep_done: done=%b required 1", done); end
    checks++;
    if (pass !== x.pass) begin failures++; $display("FAIL sweep_pass: got %b required %b", pass, x.pass); end
    checks++;
    if (cov_mask !== x.cov) begin failures++; $display("FAIL sweep_cov: got %h required %h", cov_mask, x.cov); end
    checks++;
    if ({busy, timeout, err_cnt, first_fail_vld} !== {1'b0, x.timeout, x.err, x.ffv}) begin
      failures++;
      $display("FAIL sweep_flags: busy/timeout/err/ffv got %b/%b/%0d/%b required 0/%b/%0d/%b",
               busy, timeout, err_cnt, first_fail_vld, x.timeout, x.err, x.ffv);
    end
    $display("sweep: done=%b pass=%b cov=%h err=%0d", done, pass, cov_mask, err_cnt);
  endtask

  task automatic test_fault();
    exp_t x;
    bit   ok;
    fault_mask = 16'h0040;
    fill_full_sweep();
    sb.push_back('{pass: 1'b0, timeout: 1'b0, err: 2'd1, cov: 16'hFFFF, ffv: 1'b1, ffvec: 4'h6, fmask: 16'h0040});
    run_seq(-1);
    wait_done(200, ok);
    x = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL fault_done: done=%b required 1", done); end
    checks++;
    if ({pass, err_cnt} !== {x.pass, x.err}) begin
      failures++;
      $display("FAIL fault_pass_err: got pass=%b err=%0d required pass=%b err=%0d", pass, err_cnt, x.pass, x.err);
    end
    checks++;
    if ({first_fail_vld, first_fail_vec} !== {x.ffv, x.ffvec}) begin
      failures++;
      $display("FAIL fault_first: got vld=%b vec=%h required vld=%b vec=%h",
               first_fail_vld, first_fail_vec, x.ffv, x.ffvec);
    end
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
    checks++;
    if (fail_mask !== x.fmask) begin failures++; $display("FAIL fault_mask: got %h required %h", fail_mask, x.fmask); end
`endif
    $display("fault: pass=%b err=%0d first=%b/%h", pass, err_cnt, first_fail_vld, first_fail_vec);
  endtask

  // Restarts from DONE after a failing run, so cleared results are visible.
  task automatic test_partial();
    exp_t x;
    bit   ok;
    fault_mask = 16'h0000;
    seq_q = {};
    for (int v = 0; v < 8; v++) seq_q.push_back(4'(v));
    sb.push_back('{pass: 1'b0, timeout: 1'b1, err: '0, cov: 16'h00FF, ffv: 1'b0, ffvec: 4'h0, fmask: 16'h0000});
    run_seq(-1);
    wait_done(200, ok);
    x = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL partial_done: done=%b required 1", done); end
    checks++;
    if ({timeout, pass} !== {x.timeout, x.pass}) begin
      failures++;
      $display("FAIL partial_timeout: got timeout=%b pass=%b required timeout=%b pass=%b", timeout, pass, x.timeout, x.pass);
    end
    checks++;
    if (cov_mask !== x.cov) begin failures++; $display("FAIL partial_cov: got %h required %h", cov_mask, x.cov); end
    checks++;
    if ({err_cnt, first_fail_vld} !== {x.err, x.ffv}) begin
      failures++;
      $display("FAIL partial_cleared: got err=%0d ffv=%b required err=%0d ffv=%b", err_cnt, first_fail_vld, x.err, x.ffv);
    end
    $display("partial: timeout=%b cov=%h", timeout, cov_mask);
  endtask

  task automatic test_glitch();
    exp_t x;
    bit   ok;
    fault_mask = 16'h0000;
    sb.push_back('{pass: 1'b0, timeout: 1'b1, err: '0, cov: 16'h0200, ffv: 1'b0, ffvec: 4'h0, fmask: 16'h0000});
    vec_drv = 4'h3;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    vec_drv = 4'h9;       // changes during the first settle cycle
    repeat (10) @(negedge clk);
    checks++;
    if ({busy, cov_mask} !== {1'b1, 16'h0200}) begin
      failures++;
      $display("FAIL glitch_mid: got busy=%b cov=%h required busy=1 cov=0200", busy, cov_mask);
    end
    wait_done(200, ok);
    x = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL glitch_done: done=%b required 1", done); end
    checks++;
    if ({timeout, cov_mask} !== {x.timeout, x.cov}) begin
      failures++;
      $display("FAIL glitch_end: got timeout=%b cov=%h required timeout=%b cov=%h", timeout, cov_mask, x.timeout, x.cov);
    end
    $display("glitch: cov=%h timeout=%b", cov_mask, timeout);
  endtask

  // Vector 2 is faulty and applied twice: counted twice, covered once.
  task automatic test_recheck();
    exp_t x;
    bit   ok;
    fault_mask = 16'h0004;
    seq_q = {};
    seq_q.push_back(4'h0); seq_q.push_back(4'h1); seq_q.push_back(4'h2);
    seq_q.push_back(4'h1); seq_q.push_back(4'h2);
    for (int v = 3; v < 16; v++) seq_q.push_back(4'(v));
    sb.push_back('{pass: 1'b0, timeout: 1'b0, err: 2'd2, cov: 16'hFFFF, ffv: 1'b1, ffvec: 4'h2, fmask: 16'h0004});
    run_seq(-1);
    wait_done(200, ok);
    x = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL recheck_done: done=%b required 1", done); end
    checks++;
    if ({err_cnt, cov_mask, first_fail_vec, pass} !== {x.err, x.cov, x.ffvec, x.pass}) begin
      failures++;
      $display("FAIL recheck_results: got err=%0d cov=%h ffvec=%h pass=%b required err=%0d cov=%h ffvec=%h pass=%b",
               err_cnt, cov_mask, first_fail_vec, pass, x.err, x.cov, x.ffvec, x.pass);
    end
    $display("recheck: err=%0d cov=%h", err_cnt, cov_mask);
  endtask

  task automatic test_saturation();
    exp_t x;
    bit   ok;
    fault_mask = 16'h003E;
    fill_full_sweep();
    sb.push_back('{pass: 1'b0, timeout: 1'b0, err: 2'd3, cov: 16'hFFFF, ffv: 1'b1, ffvec: 4'h1, fmask: 16'h003E});
    run_seq(-1);
    wait_done(200, ok);
    x = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL sat_done: done=%b required 1", done); end
    checks++;
    if ({err_cnt, pass} !== {x.err, x.pass}) begin
      failures++;
      $display("FAIL sat_err: got err=%0d pass=%b required err=%0d pass=%b", err_cnt, pass, x.err, x.pass);
    end
    checks++;
    if (first_fail_vec !== x.ffvec) begin failures++; $display("FAIL sat_first: got %h required %h", first_fail_vec, x.ffvec); end
`ifdef FOUR_OR_CHK_FAIL_MASK_EN
    checks++;
    if (fail_mask !== x.fmask) begin failures++; $display("FAIL sat_mask: got %h required %h", fail_mask, x.fmask); end
`endif
    $display("saturation: err=%0d pass=%b", err_cnt, pass);
  endtask

  task automatic test_reset_mid_run();
    logic [26:0] obs;
    fault_mask = 16'h0000;
    seq_q = {};
    for (int v = 4; v < 8; v++) seq_q.push_back(4'(v));
    run_seq(-1);
    checks++;
    if ({busy, cov_mask} !== {1'b1, 16'h00F0}) begin
      failures++;
      $display("FAIL midrun_cov: got busy=%b cov=%h required busy=1 cov=00F0", busy, cov_mask);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {busy, done, pass, timeout, err_cnt, cov_mask, first_fail_vld, first_fail_vec};
    checks++;
    if (obs !== 27'd0) begin failures++; $display("FAIL midrun_reset: got %h required 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset_mid_run: outputs after reset=%h", obs);
  endtask

  task automatic test_back_to_back();
    exp_t x;
    bit   ok;
    fault_mask = 16'h0000;
    fill_full_sweep();
    sb.push_back('{pass: 1'b1, timeout: 1'b0, err: '0, cov: 16'hFFFF, ffv: 1'b0, ffvec: 4'h0, fmask: 16'h0000});
    run_seq(-1);
    wait_done(200, ok);
    x = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL clean_done: done=%b required 1", done); end
    checks++;
    if ({pass, cov_mask, err_cnt} !== {x.pass, x.cov, x.err}) begin
      failures++;
      $display("FAIL clean_pass: got pass=%b cov=%h err=%0d required pass=%b cov=%h err=%0d",
               pass, cov_mask, err_cnt, x.pass, x.cov, x.err);
    end
    $display("back_to_back: pass=%b cov=%h", pass, cov_mask);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    vec_drv    = 4'h0;
    fault_mask = 16'h0000;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_sweep();
    test_fault();
    test_partial();
    test_glitch();
    test_recheck();
    test_saturation();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
